// File: rtl/reg_load_arb_pkg.sv
// Shared types and defaults for the register-load arbiter.
// Optional lock feature is enabled by defining REG_LOAD_ARB_LOCK_EN.
package reg_load_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
// Latency: none (pure combinational).
// Backpressure: none; valid is simply the OR of all requests.
module rr_pick
    import reg_load_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    logic [2*NREQ-1:0] rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;

    always_comb begin
        valid = |req;
        // Rotate so bit 0 is the highest-priority requester.
        rot   = {req, req} >> rr_ptr;
        off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = k[IDW-1:0];
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        winner = sum[IDW-1:0];
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one load-enabled register's Load/D port (lock: REG_LOAD_ARB_LOCK_EN).
// Latency: req sampled at edge k gives ack/load_o in cycle k+1; one load per 2 cycles.
// Backpressure: req is level-held until its ack pulse; losers simply wait.
module reg_load_arbiter
    import reg_load_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
`ifdef REG_LOAD_ARB_LOCK_EN
    input  logic [NREQ-1:0]    lock,
`endif
    output logic [NREQ-1:0]    ack,
    output logic               load_o,
    output logic [DW-1:0]      d_o,
    output logic [IDW-1:0]     owner,
    output logic               busy
);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic            pick_vld;
    logic [IDW-1:0]  pick_w;
    logic [IDW-1:0]  next_ptr;
    logic            hold;
    logic [DW-1:0]   words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = data[g*DW +: DW];
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .winner (pick_w)
    );

    assign next_ptr = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifdef REG_LOAD_ARB_LOCK_EN
    // Lock only matters while the owner is still asking for more.
    assign hold = lock[owner] & req[owner];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            rr_ptr <= '0;
            ack    <= '0;
            load_o <= 1'b0;
            d_o    <= '0;
            owner  <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        d_o    <= words[pick_w];
                        owner  <= pick_w;
                        ack    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_w;
                        load_o <= 1'b1;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    ack    <= '0;
                    load_o <= 1'b0;
                    busy   <= 1'b0;
                    rr_ptr <= hold ? owner : next_ptr;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_load_arbiter.md
Name: reg_load_arbiter

Overview:
- Shares the Load/D write port of one 32-bit load-enabled register between NREQ requesters.
- Round-robin arbitration with a req/ack handshake.
- Drives the register's Load and D inputs; the register's own clear is not driven here.
- Sits between producer blocks and the shared register instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data width, matching the register width.
- IDW, 2, owner-id width, equal to clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester load request; level-held until ack.
- data  in  NREQ*DW  requester i's word at bits [i*DW +: DW].
- ack  out  NREQ  one-hot, one-cycle pulse; the word is loaded at the end of this cycle.
- load_o  out  1  Load strobe to the shared register.
- d_o  out  DW  data to the register's D input.
- owner  out  IDW  index of the last or current grantee.
- busy  out  1  high while in the LOAD state.

Behaviour:
- Reset (clear=0, async), all outputs and state take these values immediately:
  - state=IDLE, ack=0, load_o=0, d_o=0, owner=0, busy=0.
  - rr_ptr=0. rr_ptr is the highest-priority index for the next arbitration.
- State machine:
  - IDLE: if any req bit is set, pick the winner w. w is the first set req bit searching from rr_ptr upward, wrapping modulo NREQ.
  - On that edge, register d_o=data[w] and owner=w, then go to LOAD.
  - LOAD: load_o=1, busy=1, ack[w]=1 for exactly this cycle; the register captures d_o at the end of this cycle.
  - Leaving LOAD: rr_ptr=(w+1) mod NREQ, then return to IDLE.
- Latency: req sampled high at edge k gives ack/load_o high in cycle k+1.
- Throughput: one load per 2 cycles; load_o and ack are never high in consecutive cycles.
- Handshake: a requester must drop req in the cycle after ack, or hold it to request another load.
  - A held req is re-arbitrated fairly; the pointer has moved past it.
- req dropping between selection and LOAD: the load still completes with the latched data, and ack is still pulsed.
- data is sampled only at the selection edge; later changes are ignored.
- Simultaneous requests are resolved purely by rr_ptr. Wrap example: NREQ=4, rr_ptr=3, req=0b1001 → winner 3, then rr_ptr=0.
- d_o and owner hold their values in IDLE; only load_o qualifies d_o.
- Reset during LOAD: load_o and ack drop asynchronously and no load occurs. The requester keeps req high and is served after reset.
- ack is always one-hot or zero.

Optional Feature:
- Macro: REG_LOAD_ARB_LOCK_EN.
- Defined:
  - Adds input lock[NREQ].
  - If lock[w] is high in the LOAD cycle, rr_ptr stays at w, giving w first priority next arbitration (back-to-back bursts).
  - Lock has no effect once req[w] drops.
  - A locked owner that keeps req high is granted every second cycle indefinitely; the requester is responsible for bounding it.
- Undefined: no lock port; rr_ptr always advances past the winner.

Decomposition:
- Package reg_load_arb_pkg:
  - state enum {IDLE, LOAD}.
  - default NREQ/DW constants.
  - a clog2 function for IDW.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, rr_ptr.
  - Outputs: valid, winner index.
  - Reusable by other arbiters in the design.

Test Plan:
- Single request:
  - Reset, then req=0b0100 with data[2]=32'hDEADBEEF.
  - Next cycle: ack=0b0100, load_o=1, d_o=32'hDEADBEEF, owner=2.
  - Register Q=32'hDEADBEEF one cycle later.
- Simultaneous requests:
  - req=0b1111 held from reset.
  - Acks in order 0,1,2,3,0, every second cycle.
  - load_o never high two cycles in a row.
- Wrap:
  - Serve requester 3 alone, then req=0b1001.
  - Winner is 0 (rr_ptr=0), then 3.
- Reset mid-load:
  - Assert clear during the LOAD cycle.
  - load_o/ack fall without a clock edge; rr_ptr=0; Q is not updated.
- Data stability:
  - Change data[1] from 32'h1 to 32'h2 during LOAD.
  - d_o stays 32'h1.
- Lock (with REG_LOAD_ARB_LOCK_EN):
  - req=0b0011, lock[0]=1 held.
  - Acks are 0,0,0…; drop lock[0] → next ack is 1.
